tlb_cache: RTL and testbench

Caching address-translation stage between the processor's 16-bit `addr` output and the 6-bit `lpmRAM` address input; it replaces the combinational `tlb`. A small fully associative translation cache holds recent page→frame mappings. On a miss it walks an external page-table memory with 1-cycle synchronous read latency, fills an entry, then completes the request. Hits complete in the same cycle. Misses stall the requester through `ready`.

---
 rtl/tlb_pkg.sv | 38 +++
 rtl/tlb_cache_if.sv | 25 ++
 rtl/tlb_entry_array.sv | 90 +++++++++
 rtl/tlb_cache.sv | 95 +++++++++
 tb/tb_tlb_cache.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared widths, FSM state encoding and page-table entry layout for the
// caching address-translation stage.
package tlb_pkg;

  localparam int VADDR_W  = 16;
  localparam int OFFSET_W = 3;
  localparam int FRAME_W  = 3;
  localparam int ENTRIES  = 4;

  localparam int VPN_W   = VADDR_W - OFFSET_W;
  localparam int PADDR_W = FRAME_W + OFFSET_W;
  localparam int PTE_W   = FRAME_W + 1;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // Page-table word: {valid, frame}
  localparam int PTE_VALID_BIT = FRAME_W;

  typedef logic [VPN_W-1:0]    vpn_t;
  typedef logic [FRAME_W-1:0]  frame_t;
  typedef logic [OFFSET_W-1:0] offset_t;
  typedef logic [IDX_W-1:0]    idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FILL  = 2'd2,
    FAULT = 2'd3
  } tlb_state_e;

  function automatic vpn_t vpn_of(input logic [VADDR_W-1:0] vaddr);
    return vaddr[VADDR_W-1:OFFSET_W];
  endfunction

  function automatic offset_t offset_of(input logic [VADDR_W-1:0] vaddr);
    return vaddr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/tlb_cache_if.sv
// Requester and page-table signals of the translation stage; the master side
// is the processor plus page-table memory, the slave side is tlb_cache.
interface tlb_cache_if;
  import tlb_pkg::*;

  logic                 req;
  logic [VADDR_W-1:0]   vaddr;
  logic                 flush;
  logic [PADDR_W-1:0]   paddr;
  logic                 ready;
  logic                 fault;
  logic [VPN_W-1:0]     pt_addr;
  logic [PTE_W-1:0]     pt_q;

  modport master (
    output req, vaddr, flush, pt_q,
    input  paddr, ready, fault, pt_addr
  );

  modport slave (
    input  req, vaddr, flush, pt_q,
    output paddr, ready, fault, pt_addr
  );

endinterface

// File: rtl/tlb_entry_array.sv
// Fully associative translation entries: parallel tag compare, one-hot hit,
// victim choice (first invalid, else round robin) and a single write port.
module tlb_entry_array
  import tlb_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   flush_i,
  input  vpn_t   lookup_vpn_i,
  output logic   hit_o,
  output frame_t hit_frame_o,
  input  logic   wr_en_i,
  input  vpn_t   wr_vpn_i,
  input  frame_t wr_frame_i
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  vpn_t               tag_q   [ENTRIES];
  frame_t             frame_q [ENTRIES];
  idx_t               rr_q, rr_d;

  logic [ENTRIES-1:0] hit_vec;
  idx_t               victim;
  logic               any_free;
  logic               wr_fire;

  // A flush in the same cycle discards the write.
  assign wr_fire = wr_en_i && !flush_i;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec[i] = valid_q[i] && (tag_q[i] == lookup_vpn_i);
    end
  end

  assign hit_o = |hit_vec;

  // Hits are one-hot, so an OR-reduction of gated frames is the mux.
  always_comb begin
    hit_frame_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit_vec[i]) hit_frame_o = hit_frame_o | frame_q[i];
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    victim   = rr_q;
    any_free = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim   = idx_t'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    if (wr_fire) begin
      valid_d[victim] = 1'b1;
      if (!any_free) rr_d = rr_q + idx_t'(1);
    end
    if (flush_i) begin
      valid_d = '0;
      rr_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  // NOTE: tag/frame storage is not reset; the valid bits alone qualify it.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      tag_q[victim]   <= wr_vpn_i;
      frame_q[victim] <= wr_frame_i;
    end
  end

endmodule

// File: rtl/tlb_cache.sv
// Caching translation stage: same-cycle hits, 3-cycle page-table walk on a
// miss, sticky fault on an invalid page-table entry until flush or reset.
module tlb_cache
  import tlb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  tlb_cache_if.slave bus
);

  tlb_state_e state_q, state_d;
  vpn_t       walk_vpn_q, walk_vpn_d;

  vpn_t       cur_vpn;
  offset_t    cur_off;
  logic       hit;
  frame_t     hit_frame;
  logic       fill_we;
  logic       pte_valid;
  frame_t     pte_frame;
  logic       ready;

  assign cur_vpn   = vpn_of(bus.vaddr);
  assign cur_off   = offset_of(bus.vaddr);
  assign pte_valid = bus.pt_q[PTE_VALID_BIT];
  assign pte_frame = bus.pt_q[FRAME_W-1:0];

  tlb_entry_array u_entries (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (bus.flush),
    .lookup_vpn_i (cur_vpn),
    .hit_o        (hit),
    .hit_frame_o  (hit_frame),
    .wr_en_i      (fill_we),
    .wr_vpn_i     (walk_vpn_q),
    .wr_frame_i   (pte_frame)
  );

  always_comb begin
    state_d    = state_q;
    walk_vpn_d = walk_vpn_q;
    ready      = 1'b0;
    fill_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (hit) begin
            ready = 1'b1;
          end else begin
            walk_vpn_d = cur_vpn;
            state_d    = WALK;
          end
        end
      end
      WALK: state_d = FILL;
      FILL: begin
        if (pte_valid) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = FAULT;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase

    // Flush overrides any request or fill in the same cycle.
    if (bus.flush) begin
      state_d    = IDLE;
      walk_vpn_d = walk_vpn_q;
      ready      = 1'b0;
      fill_we    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      walk_vpn_q <= '0;
    end else begin
      state_q    <= state_d;
      walk_vpn_q <= walk_vpn_d;
    end
  end

  assign bus.ready   = ready;
  assign bus.paddr   = ready ? {hit_frame, cur_off} : '0;
  assign bus.pt_addr = walk_vpn_q;
  // Fault shows as soon as the invalid page-table word is seen in FILL.
  assign bus.fault   = (state_q == FAULT) || ((state_q == FILL) && !pte_valid);

endmodule

// File: tb/tb_tlb_cache.sv
// Directed bench for tlb_cache with a 1-cycle-latency page-table memory model.
module tb_tlb_cache;

  logic clock = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  tlb_cache_if bus ();

  tlb_cache dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [3:0] pt_table [0:15];

  // Synchronous-read page table, same latency as lpmRAM.
  always @(posedge clock) bus.pt_q <= pt_table[bus.pt_addr[3:0]];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Miss on va, expect ready only in the 4th cycle with paddr exp_pa.
  task automatic do_miss(input string tag, input logic [15:0] va, input logic [5:0] exp_pa);
    logic [15:0] vpn;
    vpn = {3'b000, va[15:3]};
    tick();
    bus.req   = 1'b1;
    bus.vaddr = va;
    #1;
    check({tag, " c0 ready"}, bus.ready, 16'd0);
    tick(); #1;
    check({tag, " walk ready"}, bus.ready, 16'd0);
    check({tag, " walk pt_addr"}, bus.pt_addr, vpn);
    tick(); #1;
    check({tag, " fill ready"}, bus.ready, 16'd0);
    tick(); #1;
    check({tag, " c3 ready"}, bus.ready, 16'd1);
    check({tag, " c3 paddr"}, bus.paddr, exp_pa);
  endtask

  task automatic do_hit(input string tag, input logic [15:0] va, input logic [5:0] exp_pa);
    tick();
    bus.req   = 1'b1;
    bus.vaddr = va;
    #1;
    check({tag, " ready"}, bus.ready, 16'd1);
    check({tag, " paddr"}, bus.paddr, exp_pa);
  endtask

  task automatic do_flush(input string tag);
    tick();
    bus.req   = 1'b0;
    bus.flush = 1'b1;
    #1;
    check({tag, " flush ready"}, bus.ready, 16'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    check({tag, " after fault"}, bus.fault, 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pt_table[i] = 4'b0000;
    pt_table[0] = {1'b1, 3'd1};
    pt_table[1] = {1'b1, 3'd2};
    pt_table[2] = {1'b1, 3'd6};
    pt_table[3] = {1'b1, 3'd4};
    pt_table[4] = {1'b1, 3'd5};
    pt_table[5] = {1'b1, 3'd7};
    pt_table[7] = 4'b0101;

    reset     = 1'b1;
    bus.req   = 1'b0;
    bus.vaddr = '0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("reset ready", bus.ready, 16'd0);
    check("reset fault", bus.fault, 16'd0);
    check("reset pt_addr", bus.pt_addr, 16'd0);
    check("reset paddr", bus.paddr, 16'd0);

    // Cold miss then same-page hit
    do_miss("cold", 16'h0015, 6'b110_101);
    do_hit("hit2", 16'h0012, 6'b110_010);

    // Replacement: fill 0..3, vpn4 evicts entry 0
    do_flush("repl");
    do_miss("fill0", 16'h0001, 6'b001_001);
    do_miss("fill1", 16'h000A, 6'b010_010);
    do_miss("fill2", 16'h0013, 6'b110_011);
    do_miss("fill3", 16'h001C, 6'b100_100);
    do_miss("fill4", 16'h0026, 6'b101_110);
    do_hit("hit1", 16'h000F, 6'b010_111);
    do_hit("hit4", 16'h0020, 6'b101_000);
    do_hit("hit2b", 16'h0013, 6'b110_011);
    do_hit("hit3", 16'h001C, 6'b100_100);
    do_miss("evict0", 16'h0000, 6'b001_000);
    do_miss("evict1", 16'h000A, 6'b010_010);

    // Fault on vpn 7
    tick();
    bus.req   = 1'b1;
    bus.vaddr = 16'h003B;
    #1;
    check("fault c0 ready", bus.ready, 16'd0);
    tick(); #1;
    check("fault walk pt_addr", bus.pt_addr, 16'd7);
    check("fault walk fault", bus.fault, 16'd0);
    tick(); #1;
    check("fault fill fault", bus.fault, 16'd1);
    check("fault fill ready", bus.ready, 16'd0);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      check("fault hold ready", bus.ready, 16'd0);
      check("fault hold fault", bus.fault, 16'd1);
    end
    do_flush("fault");
    do_miss("post_fault", 16'h0015, 6'b110_101);

    // Flush in the FILL cycle discards the write
    tick();
    bus.req   = 1'b1;
    bus.vaddr = 16'h001C;
    #1;
    check("coll c0 ready", bus.ready, 16'd0);
    tick(); #1;
    check("coll walk pt_addr", bus.pt_addr, 16'd3);
    tick();
    bus.flush = 1'b1;
    #1;
    check("coll fill ready", bus.ready, 16'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    check("coll retry c0 ready", bus.ready, 16'd0);
    tick(); #1;
    check("coll retry walk ready", bus.ready, 16'd0);
    check("coll retry pt_addr", bus.pt_addr, 16'd3);
    tick(); #1;
    check("coll retry fill ready", bus.ready, 16'd0);
    tick(); #1;
    check("coll retry c3 ready", bus.ready, 16'd1);
    check("coll retry c3 paddr", bus.paddr, 16'(6'b100_100));

    // Reset during WALK aborts the walk and drops cached vpn 3
    tick();
    bus.req   = 1'b1;
    bus.vaddr = 16'h002D;
    #1;
    check("rst c0 ready", bus.ready, 16'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rst walk pt_addr", bus.pt_addr, 16'd5);
    tick();
    reset   = 1'b0;
    bus.req = 1'b0;
    #1;
    check("rst ready", bus.ready, 16'd0);
    check("rst fault", bus.fault, 16'd0);
    check("rst pt_addr", bus.pt_addr, 16'd0);
    check("rst paddr", bus.paddr, 16'd0);
    do_miss("rst_refill", 16'h001C, 6'b100_100);

    tick();
    bus.req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
